// File: rtl/radix16_serial_multiplier.sv
// radix16_serial_multiplier: sequential n x n unsigned multiplier that
// consumes one radix-16 digit of A per clock, LSB digit first, and
// accumulates digit*B partial products into a 2n-bit product.
// Optional build macro: RADIX16_ZERO_SHORTCUT_EN. When defined, a zero
// operand completes directly from IDLE without running the digit loop.

// Combinational 4 x n unsigned partial-product generator.
module Multiplier_4xN #(
  parameter int n = 16
) (
  input  logic [3:0]   a,
  input  logic [n-1:0] b,
  output logic [n+3:0] p
);
  logic [n+3:0] a_ext;
  logic [n+3:0] b_ext;

  assign a_ext = {{n{1'b0}}, a};
  assign b_ext = {4'b0000, b};
  assign p     = a_ext * b_ext;
endmodule

module radix16_serial_multiplier #(
  parameter int n = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   A,
  input  logic [n-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] P
);
  localparam int D     = n / 4;
  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [n-1:0]     a_sh_q, a_sh_d;
  logic [n-1:0]     b_r_q, b_r_d;
  logic [2*n-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*n-1:0]   p_q, p_d;

  logic [n+3:0]     pp;
  logic [n+3:0]     sum;
  logic [2*n-1:0]   acc_step;
  logic             zero_short;

  Multiplier_4xN #(.n(n)) u_mul (
    .a(a_sh_q[3:0]),
    .b(b_r_q),
    .p(pp)
  );

  // Upper half of acc plus the n+4-bit partial product always fits in
  // n+4 bits, so the carry out of the add lands in the top digit.
  assign sum      = {4'b0000, acc_q[2*n-1:n]} + pp;
  assign acc_step = {sum, acc_q[n-1:4]};

`ifdef RADIX16_ZERO_SHORTCUT_EN
  assign zero_short = (A == '0) || (B == '0);
`else
  assign zero_short = 1'b0;
`endif

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_r_d   = b_r_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d = A;
          b_r_d  = B;
          acc_d  = '0;
          cnt_d  = '0;
          if (zero_short) begin
            p_d     = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d  = acc_step;
        a_sh_d = a_sh_q >> 4;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          p_d     = acc_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, accumulator and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Operand registers are always reloaded on acceptance, so no reset.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_r_q  <= b_r_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign P    = p_q;
endmodule
